// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback-select encodings and hazard FSM states.
package cpu_pkg;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count enabled cycles until the all-ones ceiling is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch / memory-wait stall and flush
// generation, memory-wait timeout tracking and saturating event counters.
// TIMEOUT must be at least 2.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rf_ra0_id,
    input  logic [4:0]       rf_ra1_id,
    input  logic             rf_re0_id,
    input  logic             rf_re1_id,
    input  logic [4:0]       rf_wa_ex,
    input  logic             rf_we_ex,
    input  logic [1:0]       rf_wd_sel_ex,
    input  logic             npc_sel_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             mem_err,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_lu
);

    localparam int unsigned       WCNT_W    = $clog2(TIMEOUT) + 1;
    // The first wait cycle is spent in RUN, so WAIT sees wcnt 0..TIMEOUT-2;
    // the increment that would reach TIMEOUT-1 lands on the last allowed cycle.
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 2);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              w_lu;
    logic              w_mw;
    logic              w_flush_ev;
    logic              w_lu_ev;

    assign w_lu = rf_we_ex && (rf_wd_sel_ex == WD_MEM) && (rf_wa_ex != '0) &&
                  ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                   (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
    assign w_mw = dmem_req_mem && !dmem_ready;

    // State and wait-cycle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Next-state logic and prioritised stall/flush controls.
    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        w_flush_ev   = 1'b0;
        w_lu_ev      = 1'b0;

        case (r_state)
            RUN: begin
                if (w_mw) begin
                    w_state_nxt = WAIT;
                    w_wcnt_nxt  = '0;
                end
            end
            WAIT: begin
                if (!w_mw) begin
                    w_state_nxt = RUN;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == WCNT_LAST) begin
                    w_state_nxt = ERROR;
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            ERROR: begin
                w_state_nxt = ERROR;
            end
            default: begin
                w_state_nxt = RUN;
                w_wcnt_nxt  = '0;
            end
        endcase

        if ((r_state == ERROR) || w_mw) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (npc_sel_ex) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            w_flush_ev  = 1'b1;
        end else if (w_lu) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            w_lu_ev     = 1'b1;
        end
    end

    assign mem_err = (r_state == ERROR);

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .i_inc (stall_pc),
        .o_cnt (cnt_stall)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_flush_ev),
        .o_cnt (cnt_flush)
    );

    sat_counter #(.W(CNT_W)) u_cnt_lu (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_lu_ev),
        .o_cnt (cnt_lu)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ra0, ra1, wa;
    logic          re0, re1, we, npc, req, rdy;
    logic [1:0]    wdsel;
    logic          s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb;
    logic          mem_err;
    logic [CW-1:0] cnt_stall, cnt_flush, cnt_lu;
    logic [6:0]    act_ctl;

    int n_total = 0;
    int n_bad   = 0;

    // model: consecutive memory-wait cycles, sticky error, expected counters
    int m_run, m_stall, m_flush, m_lu;
    bit m_err;

    hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rf_ra0_id    (ra0),
        .rf_ra1_id    (ra1),
        .rf_re0_id    (re0),
        .rf_re1_id    (re1),
        .rf_wa_ex     (wa),
        .rf_we_ex     (we),
        .rf_wd_sel_ex (wdsel),
        .npc_sel_ex   (npc),
        .dmem_req_mem (req),
        .dmem_ready   (rdy),
        .stall_pc     (s_pc),
        .stall_if_id  (s_ifid),
        .stall_id_ex  (s_idex),
        .stall_ex_mem (s_exmem),
        .flush_if_id  (f_ifid),
        .flush_id_ex  (f_idex),
        .flush_mem_wb (f_memwb),
        .mem_err      (mem_err),
        .cnt_stall    (cnt_stall),
        .cnt_flush    (cnt_flush),
        .cnt_lu       (cnt_lu)
    );

    always #5 clk = ~clk;

    assign act_ctl = {s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //           flush_if_id, flush_id_ex, flush_mem_wb}
    function automatic logic [6:0] exp_ctl();
        bit mw, lu;
        mw = req && !rdy;
        lu = we && (wdsel == 2'b01) && (wa != 5'd0) &&
             ((re0 && (ra0 == wa)) || (re1 && (ra1 == wa)));
        if (m_err || mw) return 7'b1111_001;
        if (npc)         return 7'b0000_110;
        if (lu)          return 7'b1100_010;
        return 7'b0000_000;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic set_in(input int a0, input int a1, input bit e0, input bit e1,
                          input int w, input bit wen, input int sel,
                          input bit n, input bit rq, input bit rd);
        ra0 = 5'(a0); ra1 = 5'(a1); re0 = e0; re1 = e1;
        wa = 5'(w); we = wen; wdsel = 2'(sel);
        npc = n; req = rq; dmem_ready_set(rd);
    endtask

    task automatic dmem_ready_set(input bit rd);
        rdy = rd;
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, ".cnt_stall"}, 32'(cnt_stall), 32'(m_stall));
        check_val({tag, ".cnt_flush"}, 32'(cnt_flush), 32'(m_flush));
        check_val({tag, ".cnt_lu"},    32'(cnt_lu),    32'(m_lu));
        check_val({tag, ".mem_err"},   32'(mem_err),   32'(m_err));
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input string tag);
        logic [6:0] e;
        bit mw;
        @(negedge clk);
        e = exp_ctl();
        check_val({tag, ".ctl"}, 32'(act_ctl), 32'(e));
        check_counters(tag);
        @(posedge clk);
        mw = req && !rdy;
        if (e[6])             m_stall = sat_inc(m_stall);
        if (e == 7'b0000_110) m_flush = sat_inc(m_flush);
        if (e == 7'b1100_010) m_lu    = sat_inc(m_lu);
        if (!m_err) begin
            if (mw) begin
                m_run++;
                if (m_run >= TMO) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    // Off-edge reset pulse; everything must clear without a clock.
    task automatic async_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        m_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0; m_lu = 0;
        check_counters({tag, ".rst"});
        check_val({tag, ".rst.ctl"}, 32'(act_ctl), 32'(exp_ctl()));
        #1 rst = 1'b0;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0; m_lu = 0;
        #12;
        check_counters("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // load-use: EX loads x5, ID reads x5 through port 1
        set_in(0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
        cycle("lu");
        idle();
        cycle("lu_post");
        set_in(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        cycle("lu_x0");
        set_in(0, 5, 0, 0, 5, 1, 1, 0, 0, 0);
        cycle("lu_nore");
        set_in(5, 0, 1, 0, 5, 1, 2, 0, 0, 0);
        cycle("lu_pc4");
        idle();
        cycle("lu_end");

        // branch together with load-use: branch wins
        async_reset("br");
        set_in(0, 5, 0, 1, 5, 1, 1, 1, 0, 0);
        cycle("br_lu");
        idle();
        cycle("br_post");

        // three-cycle memory wait, then ready
        async_reset("mw");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) cycle("mw_wait");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("mw_ready");
        idle();
        cycle("mw_post");

        // back-to-back waits just under the timeout
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (TMO - 1) cycle("b2b_a");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("b2b_rdy");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (TMO - 1) cycle("b2b_b");
        idle();
        cycle("b2b_post");

        // timeout: error is sticky and forces stalls regardless of inputs
        async_reset("tmo");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (TMO + 2) cycle("tmo_wait");
        set_in(0, 5, 0, 1, 5, 1, 1, 1, 0, 1);
        repeat (3) cycle("tmo_err");
        async_reset("tmo_clr");
        idle();
        cycle("tmo_run");

        // saturation of cnt_lu
        async_reset("sat");
        set_in(3, 0, 1, 0, 3, 1, 1, 0, 0, 0);
        repeat (10) cycle("sat_lu");
        idle();
        cycle("sat_post");

        // reset during the second wait cycle; a fresh wait counts from zero
        async_reset("mid");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("mid_w1");
        async_reset("mid_w2");
        repeat (TMO - 1) cycle("mid_again");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("mid_rdy");
        idle();
        cycle("mid_post");

        // random traffic
        async_reset("rnd");
        for (int i = 0; i < 3000; i++) begin
            set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   bit'($urandom % 2), bit'($urandom % 2),
                   int'($urandom_range(0, 3)), bit'(($urandom % 4) != 0),
                   int'($urandom_range(0, 3)), bit'(($urandom % 6) == 0),
                   bit'($urandom % 2), bit'(($urandom % 3) == 0));
            if (($urandom % 150) == 0) async_reset("rnd_rst");
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall/flush controller for the 5-stage CPU; the complement of the forwarding path. It detects what forwarding cannot resolve: load-use hazards, taken control transfers in EX, and multi-cycle data-memory accesses in MEM. From these it drives the per-stage stall/flush controls of the PC and the pipeline registers. It also tracks memory-wait duration against a timeout, with a sticky error state, and keeps saturating performance counters for the debug unit.

## Interface
Parameters:
- `TIMEOUT`, default 16: max consecutive MEM-wait cycles before error
- `CNT_W`, default 32: width of each performance counter

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rf_ra0_id`, `rf_ra1_id`  in  5  source register addresses of the instruction in ID
- `rf_re0_id`, `rf_re1_id`  in  1  ID actually reads the matching source
- `rf_wa_ex`  in  5  destination of the instruction in EX
- `rf_we_ex`  in  1  EX writes the register file
- `rf_wd_sel_ex`  in  2  EX writeback select; 2'b00 = ALU, 2'b01 = memory load, 2'b10 = PC+4
- `npc_sel_ex`  in  1  taken branch or jump resolved in EX
- `dmem_req_mem`  in  1  MEM stage is issuing a data-memory access
- `dmem_ready`  in  1  data memory completes the access this cycle
- `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem`  out  1  hold the register
- `flush_if_id`, `flush_id_ex`, `flush_mem_wb`  out  1  load a bubble
- `mem_err`  out  1  sticky memory timeout
- `cnt_stall`, `cnt_flush`, `cnt_lu`  out  `CNT_W`  counters for stall cycles, flush events and load-use bubbles

## Operation
- **Load-use hazard (`lu`):**
  - Asserted when `rf_we_ex` is 1, `rf_wd_sel_ex` is 2'b01 and `rf_wa_ex` is not 0.
  - In addition, either (`rf_re0_id` is 1 and `rf_ra0_id` equals `rf_wa_ex`) or (`rf_re1_id` is 1 and `rf_ra1_id` equals `rf_wa_ex`).
- **Memory wait (`mw`):** `dmem_req_mem` is 1 and `dmem_ready` is 0.
- **Priority, highest first:**
  - **ERROR state:** all four stalls are 1 and `flush_mem_wb` is 1; all other flushes are 0.
  - **`mw`:** all four stalls are 1 and `flush_mem_wb` is 1. The branch or load in EX is held, so it is re-evaluated after the wait.
  - **`npc_sel_ex`:** `flush_if_id` and `flush_id_ex` are 1; no stalls. A simultaneous `lu` is ignored because the ID instruction is squashed.
  - **`lu`:** `stall_pc` and `stall_if_id` are 1, and `flush_id_ex` is 1 for exactly one bubble.
  - **Otherwise:** all controls are 0.
- **FSM:**
  - **RUN:** go to WAIT on `mw`.
  - **WAIT:** cycle counter `wcnt` increments each cycle that `mw` holds.
    - Return to RUN when `dmem_ready` is 1 or `dmem_req_mem` drops.
    - Go to ERROR when `wcnt` reaches `TIMEOUT`-1 while still in `mw`.
  - **ERROR:** absorbing until `rst`; `mem_err` is 1.
- **Counters:** saturate at all-ones and never wrap.
  - `cnt_stall` increments in any cycle where `stall_pc` is 1.
  - `cnt_flush` increments on each `npc_sel_ex` flush.
  - `cnt_lu` increments on each load-use bubble.

## Timing
- All stall/flush outputs are combinational from the inputs and the current FSM state, valid in the same cycle. Zero latency is required for correct pipeline holding.
- FSM, `wcnt`, `mem_err` and the counters update on the rising edge of `clk`.
- On `rst`, immediately and asynchronously: state becomes RUN, `wcnt` is 0, `mem_err` is 0 and all counters are 0. Stall/flush outputs then follow the inputs with RUN priority.
- A `dmem_ready` in the first request cycle gives no stall and no WAIT entry.
- A WAIT of N cycles, with N < `TIMEOUT`, produces exactly N stall cycles. WAIT then exits on the cycle `dmem_ready` is 1, with that cycle unstalled.
- Back-to-back requests: re-entering WAIT in the cycle after exit restarts `wcnt` at 0.
- A load-use bubble lasts one cycle. In the next cycle the load is in MEM and forwarding covers the dependency.
- Asserting `rst` mid-WAIT or in ERROR aborts immediately; no partial counter update is retained.

## Structure
- Shared `cpu_pkg` holds:
  - the `rf_wd_sel` encodings (`WD_ALU`, `WD_MEM`, `WD_PC4`)
  - the FSM state enum (RUN, WAIT, ERROR)
- One natural sub-module, `sat_counter`, parameterised by width, with increment enable and asynchronous reset. It is instantiated three times.
- The hazard compare and priority mux stay inline in `hazard_ctrl`.

## Test plan
- **Load-use:**
  - Stimulus: EX is a load to x5 (`rf_wd_sel_ex`=01, `rf_we_ex`=1); ID reads `rf_ra1_id`=5 with `rf_re1_id`=1.
  - Required: `stall_pc`, `stall_if_id` and `flush_id_ex` are 1 for one cycle, and `cnt_lu` becomes 1.
  - Repeat with `rf_wa_ex`=0 or `rf_re1_id`=0: no stall.
- **Branch plus load-use in the same cycle:**
  - Stimulus: `npc_sel_ex`=1 together with the load-use condition above.
  - Required: only `flush_if_id` and `flush_id_ex` are 1, stalls are 0, `cnt_flush` is 1 and `cnt_lu` is 0.
- **Memory wait:**
  - Stimulus: `dmem_req_mem`=1 with `dmem_ready`=0 for 3 cycles, then 1.
  - Required: all four stalls and `flush_mem_wb` are 1 for exactly 3 cycles, the 4th cycle is clear, and `cnt_stall` is 3.
- **Timeout:**
  - Stimulus: `TIMEOUT`=4, with `dmem_ready` held at 0.
  - Required: `mem_err` rises after the 4th wait cycle, and all stalls stay at 1 indefinitely.
  - Then assert `rst`: `mem_err` goes to 0 and the state returns to RUN.
- **Saturation:**
  - Stimulus: `CNT_W`=3, with 10 load-use events.
  - Required: `cnt_lu` holds at 7.
- **Reset mid-WAIT:**
  - Stimulus: `rst` pulsed asynchronously (off-edge) during cycle 2 of a wait.
  - Required: counters read 0 and the FSM is in RUN, after which a new wait counts from 0.
